hilo_muldiv: RTL
================

Name: hilo_muldiv

Overview:
- Iterative multiply/divide unit with the architectural HI/LO register pair. Sits directly downstream of the control unit.
- Consumes the control unit's HI/LO write enables and HI/LO read select.
- Produces the value muxed back to the register-file write path for mfhi/mflo.
- Raises busy so the datapath stalls issue while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  launch operation (single-cycle strobe)
- op  input  2  00 multu, 01 mult, 10 divu, 11 div
- a  input  WIDTH  multiplicand / dividend (rs)
- b  input  WIDTH  multiplier / divisor (rt)
- hi_we  input  1  mthi write enable (HI_en)
- lo_we  input  1  mtlo write enable (LO_en)
- wr_data  input  WIDTH  mthi/mtlo data
- hilo_sel  input  1  read select: 1 selects HI, 0 selects LO (HiLo_sel)
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO are updated by an operation
- div_zero  output  1  one-cycle pulse with done when a divide had b==0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- rd_data  output  WIDTH  combinational: hilo_sel ? hi : lo

Behaviour:
- Reset (async, rst=0): hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0. Deassertion is synchronous to clk. Reset mid-operation aborts the operation; no HI/LO update follows.
- States: IDLE, RUN, FIX.
- IDLE:
  - If start=1 at the edge, the unit latches op and the operand magnitudes. Signed ops take |a| and |b|; unsigned ops take operands as-is. The sign-correction flags are recorded and state moves to RUN.
  - busy=1 from the next cycle.
- RUN:
  - Exactly WIDTH cycles, counter 0..WIDTH-1.
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - Transition to FIX after the counter reaches WIDTH-1.
- FIX (one cycle):
  - Sign correction is applied and the results are written at the FIX→IDLE edge.
  - Multiply: {hi,lo} = 2*WIDTH product, negated (two's complement) if signed and the operand signs differ.
  - Divide: lo = quotient, hi = remainder. For signed ops, the quotient is negated if signs differ and the remainder takes the sign of a.
  - done=1 and busy=0 in the cycle following that edge.
- Latency: start edge E0; busy high for WIDTH+1 cycles (33); HI/LO and done valid after edge E0+WIDTH+1.
- start while busy=1: ignored, with no effect on the in-flight operation.
- hi_we/lo_we:
  - Write wr_data to hi/lo at the edge only when state=IDLE and start=0.
  - Ignored while busy.
  - Same cycle as an accepted start: start wins and the write is dropped.
  - hi_we and lo_we together: both written.
- Divide by zero (b==0, either signedness): lo=all ones, hi=original a (unsigned dividend bits, no sign fix). div_zero pulses with done.
- Signed overflow, div with a=0x80000000 and b=0xFFFFFFFF: lo=0x80000000, hi=0, div_zero=0.
- done and div_zero are registered. Both are low in every cycle except the single completion cycle.
- rd_data tracks hi/lo combinationally, including during busy. It shows the old values until the FIX writeback.

Optional Feature:
- Macro: MULDIV_DIV_EN.
- Defined: divide path, div_zero logic, and signed remainder fix are compiled in, as described above.
- Undefined: divider hardware is removed. start with op[1]=1 is ignored: no busy, no done, HI/LO unchanged. div_zero is tied to 0. Multiply behaviour and latency are identical.

Test Plan:
- multu: a=0xFFFFFFFF, b=0xFFFFFFFF, start -> busy 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- mult: a=0xFFFFFFFE (-2), b=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. Also verify rd_data equals hi when hilo_sel=1 and lo when hilo_sel=0.
- div: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. A second run with divu, a=100, b=7 -> lo=14, hi=2.
- div_zero: divu a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_zero=1 for one cycle. Also div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Collisions:
  - Second start at cycle 10 of a mult -> ignored; result matches the first op.
  - hi_we with wr_data=0xAAAA while busy -> hi unchanged.
  - hi_we together with start in IDLE -> write dropped.
  - lo_we in IDLE -> lo=wr_data next cycle.
- Reset: assert rst=0 at RUN cycle 15 -> hi=lo=0, busy=0 immediately, no done afterwards. A fresh multu 3*5 after release -> lo=15, hi=0.

Source files
------------

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative shift-add multiplier / restoring divider that owns the HI/LO pair.
// Define MULDIV_DIV_EN to build the divider; without it only mult/multu are accepted.
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             hilo_sel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [1:0]       S_IDLE   = 2'd0;
  localparam logic [1:0]       S_RUN    = 2'd1;
  localparam logic [1:0]       S_FIX    = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic                    sgn);
    return (sgn && (v < 0)) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                   input logic               neg);
    return neg ? -v : v;
  endfunction

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               start_ok;
  logic               neg_res;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               res_dz;

`ifdef MULDIV_DIV_EN
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? -v : v;
  endfunction

  logic               is_div;
  logic               neg_rem;
  logic               b_zero;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH:0]     div_cand;
  logic [WIDTH:0]     div_diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_new;

  assign start_ok = start && (state == S_IDLE);
`else
  // Divide requests are dropped at the door when the divider is not built.
  assign start_ok = start && (state == S_IDLE) && !op[1];
`endif

  assign a_mag   = magnitude(a, op[0]);
  assign b_mag   = magnitude(b, op[0]);
  assign busy    = (state != S_IDLE);
  assign rd_data = hilo_sel ? hi : lo;

  // One iteration: acc = {partial product, remaining multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, opnd} & {(WIDTH+1){acc[0]}});
    acc_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    div_cand = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_cand - {1'b0, opnd};
    q_bit    = ~div_diff[WIDTH];
    rem_new  = q_bit ? div_diff[WIDTH-1:0] : div_cand[WIDTH-1:0];
    if (is_div) begin
      acc_next = {rem_new, acc[WIDTH-2:0], q_bit};
    end
`endif
  end

  // Sign fix-up applied during FIX, written back at the FIX->IDLE edge.
  always_comb begin
    {res_hi, res_lo} = cond_neg2(acc, neg_res);
    res_dz           = 1'b0;
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      if (b_zero) begin
        res_hi = a_orig;
        res_lo = '1;
        res_dz = 1'b1;
      end else begin
        res_hi = cond_neg(acc[2*WIDTH-1:WIDTH], neg_rem);
        res_lo = cond_neg(acc[WIDTH-1:0], neg_res);
      end
    end
`endif
  end

  // Datapath registers: operands latched on accepted start, iterated while RUN.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      neg_res <= op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
      is_div  <= op[1];
      neg_rem <= op[0] && a[WIDTH-1];
      b_zero  <= (b == '0);
      a_orig  <= a;
      if (op[1]) begin
        acc  <= {{WIDTH{1'b0}}, a_mag};
        opnd <= b_mag;
      end else begin
        acc  <= {{WIDTH{1'b0}}, b_mag};
        opnd <= a_mag;
      end
`else
      acc  <= {{WIDTH{1'b0}}, b_mag};
      opnd <= a_mag;
`endif
    end else if (state == S_RUN) begin
      acc <= acc_next;
    end
  end

  // Control and architectural HI/LO state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state <= S_RUN;
            cnt   <= '0;
          end else if (!start) begin
            if (hi_we) hi <= wr_data;
            if (lo_we) lo <= wr_data;
          end
        end
        S_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= S_FIX;
            cnt   <= '0;
          end
        end
        S_FIX: begin
          hi       <= res_hi;
          lo       <= res_lo;
          done     <= 1'b1;
          div_zero <= res_dz;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
